// File: rtl/fd_pkg.sv
// Shared types for the fetch/decode stage: opcodes, FSM states, jump kinds and the control bundle.
// FD_CALL_EN enables the CALL/RET opcodes.
package fd_pkg;

  localparam logic [3:0] OP_STA  = 4'b1000;
  localparam logic [3:0] OP_CLC  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_JC   = 4'b1011;
  localparam logic [3:0] OP_CALL = 4'b1100;
  localparam logic [3:0] OP_RET  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    FETCH,
    OPER,
    HALT
  } fd_state_t;

  typedef enum logic [1:0] {
    JK_NONE,
    JK_JMP,
    JK_JC,
    JK_CALL
  } jump_kind_t;

  typedef struct packed {
    logic [3:0] RegAddr;
    logic [2:0] ALUCode;
    logic       Reg_CE;
    logic       CY_CE;
    logic       A_CE;
    logic       ResetCY;
  } fd_ctrl_t;

endpackage

// File: rtl/fd_decoder.sv
// Combinational instruction decoder: one instruction word in, datapath controls and sequencing flags out.
// With FD_CALL_EN, CALL is a two-word op and RET raises is_ret; otherwise both decode as NOP.
module fd_decoder
  import fd_pkg::*;
#(
  parameter int INSTR_W = 8
) (
  input  logic [INSTR_W-1:0] instr,
  output fd_ctrl_t           ctrl,
  output jump_kind_t         jump_kind,
  output logic               is_two_word,
`ifdef FD_CALL_EN
  output logic               is_ret,
`endif
  output logic               is_halt
);

  logic [3:0] op;
  logic [3:0] n;

  assign op = instr[7:4];
  assign n  = instr[3:0];

  always_comb begin
    ctrl        = '0;
    jump_kind   = JK_NONE;
    is_two_word = 1'b0;
    is_halt     = 1'b0;
`ifdef FD_CALL_EN
    is_ret      = 1'b0;
`endif
    if (!op[3]) begin
      ctrl.ALUCode = op[2:0];
      ctrl.RegAddr = n;
      ctrl.A_CE    = 1'b1;
      ctrl.CY_CE   = 1'b1;
    end else begin
      case (op)
        OP_STA: begin
          ctrl.Reg_CE  = 1'b1;
          ctrl.RegAddr = n;
        end
        OP_CLC:  ctrl.ResetCY = 1'b1;
        OP_JMP: begin
          jump_kind   = JK_JMP;
          is_two_word = 1'b1;
        end
        OP_JC: begin
          jump_kind   = JK_JC;
          is_two_word = 1'b1;
        end
`ifdef FD_CALL_EN
        OP_CALL: begin
          jump_kind   = JK_CALL;
          is_two_word = 1'b1;
        end
        OP_RET:  is_ret = 1'b1;
`endif
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: owns the PC, sequences one- and two-word instructions, registers datapath controls.
// Optional FD_CALL_EN adds a single-level CALL/RET return register.
module fetch_decode_unit
  import fd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               cy,
  output logic [ADDR_W-1:0]  addr,
  output logic [3:0]         RegAddr,
  output logic [2:0]         ALUCode,
  output logic               Reg_CE,
  output logic               CY_CE,
  output logic               A_CE,
  output logic               ResetCY,
  output logic               halted
);

  fd_state_t         state_q, state_d;
  jump_kind_t        jk_q, jk_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, target;
  fd_ctrl_t          ctrl_d, ctrl_p1;
  logic              jump_taken;

  fd_ctrl_t          dec_ctrl;
  jump_kind_t        dec_jk;
  logic              dec_two_word;
  logic              dec_halt;
`ifdef FD_CALL_EN
  logic              dec_ret;
  logic [ADDR_W-1:0] ret_addr, ret_d;
`endif

  fd_decoder #(
    .INSTR_W(INSTR_W)
  ) u_decoder (
    .instr      (instr),
    .ctrl       (dec_ctrl),
    .jump_kind  (dec_jk),
    .is_two_word(dec_two_word),
`ifdef FD_CALL_EN
    .is_ret     (dec_ret),
`endif
    .is_halt    (dec_halt)
  );

  assign pc_inc = pc_q + ADDR_W'(1);
  assign target = instr[ADDR_W-1:0];

  // jk_q remembers which two-word op owns the operand currently on instr
  always_comb begin
    jump_taken = (jk_q == JK_JMP) || ((jk_q == JK_JC) && cy);
`ifdef FD_CALL_EN
    if (jk_q == JK_CALL) jump_taken = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    jk_d    = jk_q;
    ctrl_d  = '0;
`ifdef FD_CALL_EN
    ret_d   = ret_addr;
`endif
    case (state_q)
      FETCH: begin
        if (dec_halt) begin
          state_d = HALT;
        end else if (dec_two_word) begin
          jk_d    = dec_jk;
          pc_d    = pc_inc;
          state_d = OPER;
`ifdef FD_CALL_EN
        end else if (dec_ret) begin
          pc_d = ret_addr;
`endif
        end else begin
          ctrl_d = dec_ctrl;
          pc_d   = pc_inc;
        end
      end
      OPER: begin
        state_d = FETCH;
        pc_d    = jump_taken ? target : pc_inc;
`ifdef FD_CALL_EN
        if (jk_q == JK_CALL) ret_d = pc_inc;
`endif
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= FETCH;
      jk_q     <= JK_NONE;
      pc_q     <= '0;
      ctrl_p1  <= '0;
`ifdef FD_CALL_EN
      ret_addr <= '0;
`endif
    end else begin
      state_q  <= state_d;
      jk_q     <= jk_d;
      pc_q     <= pc_d;
      ctrl_p1  <= ctrl_d;
`ifdef FD_CALL_EN
      ret_addr <= ret_d;
`endif
    end
  end

  // p1: registered controls, valid the cycle after the instruction word was presented
  assign addr    = pc_q;
  assign RegAddr = ctrl_p1.RegAddr;
  assign ALUCode = ctrl_p1.ALUCode;
  assign Reg_CE  = ctrl_p1.Reg_CE;
  assign CY_CE   = ctrl_p1.CY_CE;
  assign A_CE    = ctrl_p1.A_CE;
  assign ResetCY = ctrl_p1.ResetCY;
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: instruction-level program model checked every cycle plus directed literal checks.
// Build with FD_CALL_EN defined to exercise CALL/RET.
module tb_fetch_decode_unit;

`ifdef FD_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif

  logic       clk;
  logic       Reset;
  logic [7:0] instr;
  logic       cy;
  logic [4:0] addr;
  logic [3:0] RegAddr;
  logic [2:0] ALUCode;
  logic       Reg_CE, CY_CE, A_CE, ResetCY, halted;

  logic [7:0] mem [32];
  assign instr = mem[addr];

  fetch_decode_unit #(
    .ADDR_W (5),
    .INSTR_W(8)
  ) dut (
    .clk    (clk),
    .Reset  (Reset),
    .instr  (instr),
    .cy     (cy),
    .addr   (addr),
    .RegAddr(RegAddr),
    .ALUCode(ALUCode),
    .Reg_CE (Reg_CE),
    .CY_CE  (CY_CE),
    .A_CE   (A_CE),
    .ResetCY(ResetCY),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Program-level model: mode 0 = fetching, 1 = operand word, 2 = halted
  int m_pc, m_mode, m_kind, m_ret;
  int m_reg, m_alu, m_rce, m_cyce, m_ace, m_rcy;
  int w, op;
  bit taken;

  task automatic m_clear();
    m_reg = 0; m_alu = 0; m_rce = 0; m_cyce = 0; m_ace = 0; m_rcy = 0;
  endtask

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m_pc = 0; m_mode = 0; m_kind = 0; m_ret = 0;
      m_clear();
    end else begin
      w  = int'(mem[m_pc]);
      op = w / 16;
      if (m_mode == 0) begin
        m_clear();
        if (op < 8) begin
          m_alu = op; m_reg = w % 16; m_ace = 1; m_cyce = 1;
          m_pc = (m_pc + 1) % 32;
        end else if (op == 8) begin
          m_rce = 1; m_reg = w % 16;
          m_pc = (m_pc + 1) % 32;
        end else if (op == 9) begin
          m_rcy = 1;
          m_pc = (m_pc + 1) % 32;
        end else if (op == 10 || op == 11 || (CALL_EN && op == 12)) begin
          m_kind = op; m_mode = 1;
          m_pc = (m_pc + 1) % 32;
        end else if (CALL_EN && op == 13) begin
          m_pc = m_ret;
        end else if (op == 15) begin
          m_mode = 2;
        end else begin
          m_pc = (m_pc + 1) % 32;
        end
      end else if (m_mode == 1) begin
        m_clear();
        taken = (m_kind == 10) || (m_kind == 12) || (m_kind == 11 && cy);
        if (m_kind == 12) m_ret = (m_pc + 1) % 32;
        m_pc   = taken ? (w % 32) : (m_pc + 1) % 32;
        m_mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("addr", int'(addr), m_pc);
    chk("RegAddr", int'(RegAddr), m_reg);
    chk("ALUCode", int'(ALUCode), m_alu);
    chk("Reg_CE", int'(Reg_CE), m_rce);
    chk("CY_CE", int'(CY_CE), m_cyce);
    chk("A_CE", int'(A_CE), m_ace);
    chk("ResetCY", int'(ResetCY), m_rcy);
    chk("halted", int'(halted), (m_mode == 2) ? 1 : 0);
  end

  task automatic expect_out(input string tag, input int a, input int ra, input int alu,
                            input int rce, input int cyce, input int ace, input int rcy,
                            input int h);
    chk({tag, ".addr"}, int'(addr), a);
    chk({tag, ".RegAddr"}, int'(RegAddr), ra);
    chk({tag, ".ALUCode"}, int'(ALUCode), alu);
    chk({tag, ".Reg_CE"}, int'(Reg_CE), rce);
    chk({tag, ".CY_CE"}, int'(CY_CE), cyce);
    chk({tag, ".A_CE"}, int'(A_CE), ace);
    chk({tag, ".ResetCY"}, int'(ResetCY), rcy);
    chk({tag, ".halted"}, int'(halted), h);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    Reset = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
  endtask

  task automatic start(input string tag);
    Reset = 1'b1;
    #1;
    expect_out({tag, ".rst"}, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    cy    = 1'b0;
    clear_mem();

    // ALU, STA, CLC, HALT
    mem[0] = 8'h31; mem[1] = 8'h82; mem[2] = 8'h90; mem[3] = 8'hF0;
    start("t1");
    chk("t1.addr0", int'(addr), 0);
    tick(); expect_out("t1.alu", 1, 1, 3, 0, 1, 1, 0, 0);
    tick(); expect_out("t1.sta", 2, 2, 0, 1, 0, 0, 0, 0);
    tick(); expect_out("t1.clc", 3, 0, 0, 0, 0, 0, 1, 0);
    tick(); expect_out("t1.halt", 3, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    expect_out("t1.frozen", 3, 0, 0, 0, 0, 0, 0, 1);

    // JMP at 4
    clear_mem();
    mem[4] = 8'hA0; mem[5] = 8'h11;
    start("t2");
    repeat (4) tick();
    chk("t2.addr4", int'(addr), 4);
    tick(); expect_out("t2.oper", 5, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_out("t2.jump", 17, 0, 0, 0, 0, 0, 0, 0);

    // Async reset pulse while in OPER
    repeat (14) tick();
    repeat (5) tick();
    chk("t5.addr4", int'(addr), 4);
    tick();
    chk("t5.oper", int'(addr), 5);
    #1 Reset = 1'b1;
    #1 expect_out("t5.async", 0, 0, 0, 0, 0, 0, 0, 0);
    #2 Reset = 1'b0;
    chk("t5.held", int'(addr), 0);
    tick();
    chk("t5.refetch", int'(addr), 1);

    // JC at 6, not taken then taken
    clear_mem();
    mem[6] = 8'hB0; mem[7] = 8'h02;
    cy = 1'b0;
    start("t3a");
    repeat (6) tick();
    chk("t3a.addr6", int'(addr), 6);
    tick(); chk("t3a.addr7", int'(addr), 7);
    tick(); chk("t3a.addr8", int'(addr), 8);

    clear_mem();
    mem[6] = 8'hB0; mem[7] = 8'h02;
    cy = 1'b1;
    start("t3b");
    repeat (6) tick();
    chk("t3b.addr6", int'(addr), 6);
    tick(); chk("t3b.addr7", int'(addr), 7);
    tick(); chk("t3b.addr2", int'(addr), 2);
    cy = 1'b0;

    // Wrap: NOPs at 30,31 roll to 0
    clear_mem();
    mem[0] = 8'hA0; mem[1] = 8'h1E;
    start("t4a");
    repeat (2) tick();
    chk("t4a.addr30", int'(addr), 30);
    tick(); chk("t4a.addr31", int'(addr), 31);
    tick(); chk("t4a.addr0", int'(addr), 0);
    tick(); chk("t4a.addr1", int'(addr), 1);

    // JMP at 31 takes its operand from word 0
    clear_mem();
    mem[0] = 8'h0C; mem[1] = 8'hA0; mem[2] = 8'h1F; mem[31] = 8'hA0;
    start("t4b");
    tick(); expect_out("t4b.alu", 1, 12, 0, 0, 1, 1, 0, 0);
    repeat (2) tick();
    chk("t4b.addr31", int'(addr), 31);
    tick(); expect_out("t4b.oper", 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); chk("t4b.addr12", int'(addr), 12);

    // CALL at 2 to 10, RET at 10
    clear_mem();
    mem[2] = 8'hC0; mem[3] = 8'h0A; mem[10] = 8'hD0;
    start("t6");
    repeat (2) tick();
    chk("t6.addr2", int'(addr), 2);
    tick(); chk("t6.addr3", int'(addr), 3);
`ifdef FD_CALL_EN
    tick(); expect_out("t6.call", 10, 0, 0, 0, 0, 0, 0, 0);
    tick(); expect_out("t6.ret", 4, 0, 0, 0, 0, 0, 0, 0);
`else
    tick(); expect_out("t6.nop", 4, 10, 0, 0, 1, 1, 0, 0);
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Replaces the bench-only program-memory model with a synthesizable fetch/decode stage between program memory and RF_ALU_CY_A_module.
- Owns the program counter and drives the memory address.
- Decodes the 8-bit instruction returned combinationally by memory into registered datapath controls.
- Adds JMP, JC and HALT via a small FSM.

Parameters:
ADDR_W, 5, program address width; PC wraps at 2^ADDR_W.
INSTR_W, 8, instruction width; fixed encoding below requires 8.

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
instr  in  INSTR_W  instruction/operand word at addr, combinational from memory
cy  in  1  carry flag from datapath CY register
addr  out  ADDR_W  program address (= PC)
RegAddr  out  4  register-file address
ALUCode  out  3  ALU operation select
Reg_CE  out  1  register-file write enable
CY_CE  out  1  carry register enable
A_CE  out  1  accumulator enable
ResetCY  out  1  synchronous carry clear
halted  out  1  high while in HALT

Behaviour:
- Clock and reset: one clock `clk`; `Reset` is asynchronous and active-high.
- Reset values (Reset high, async):
  - PC = 0, state = FETCH.
  - All control outputs = 0; `halted` = 0.
  - Reset asserted mid-operand (state OPER) aborts the jump.
- Encoding (instr[7:4] = op, instr[3:0] = n):
  - 0xxx ALU: ALUCode = instr[6:4], RegAddr = n, A_CE = 1, CY_CE = 1.
  - 1000 STA: Reg_CE = 1, RegAddr = n.
  - 1001 CLC: ResetCY = 1.
  - 1010 JMP: two-word; next word [ADDR_W-1:0] = target, upper bits ignored.
  - 1011 JC: two-word; jumps only if cy = 1.
  - 1111 HALT.
  - All other opcodes: NOP (all controls 0).
- FSM states FETCH, OPER, HALT:
  - FETCH, single-word op: decoded controls registered at the edge; PC <= PC+1.
  - FETCH, JMP/JC: latch the jump kind; controls <= 0; PC <= PC+1; next state OPER.
  - OPER, taken (JMP, or JC with cy = 1 sampled this cycle): PC <= instr[ADDR_W-1:0].
  - OPER, not taken: PC <= PC+1.
  - OPER: controls <= 0; next state FETCH.
  - FETCH, HALT: controls <= 0; PC holds; next state HALT.
  - HALT: `halted` = 1, PC frozen, controls 0; only Reset exits.
- Latency:
  - Controls are valid in the cycle after the instruction is presented on `instr`. The datapath applies them at the following edge.
  - A JC fetched right after an ALU op sees that op's updated cy in OPER; no hazard or stall is required.
- Wrap-around:
  - PC = 2^ADDR_W-1 increments to 0.
  - A two-word op at the last address takes its operand from address 0.
- Arithmetic: PC arithmetic is modulo 2^ADDR_W.

Optional Feature:
- Macro: FD_CALL_EN.
- When defined:
  - Adds one-level return register `ret_addr` (ADDR_W bits, reset 0).
  - 1100 CALL: two-word, unconditional. In OPER, `ret_addr` <= PC+1 (address after the operand word); PC <= target.
  - 1101 RET: single-word. PC <= `ret_addr`; controls 0.
  - A second CALL overwrites `ret_addr`; there is no stack.
- When undefined: 1100 and 1101 decode as NOP, and `ret_addr` does not exist.

Decomposition:
- Package fd_pkg contains:
  - opcode localparams (OP_STA, OP_CLC, OP_JMP, OP_JC, OP_CALL, OP_RET, OP_HALT)
  - enum fd_state_t {FETCH, OPER, HALT}
  - jump-kind enum
  - packed struct fd_ctrl_t {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY}
- Sub-module fd_decoder:
  - Purely combinational: instr -> fd_ctrl_t plus is_two_word / is_halt flags.
  - The top module holds the PC, FSM and output register.

Test Plan:
1. Reset released, program 0x31, 0x82, 0x90, 0xF0: addr 0,1,2,3. Then:
   - cycle after fetch 0: A_CE = CY_CE = 1, ALUCode = 3, RegAddr = 1
   - next cycle: Reg_CE = 1, RegAddr = 2
   - next cycle: ResetCY = 1
   - `halted` = 1 and addr stays 3 forever.
2. JMP at 4 with operand 0x11: addr 4, 5, 17. Controls stay 0 for both JMP cycles.
3. JC at 6 with operand 0x02:
   - cy = 0 in OPER: addr 6, 7, 8.
   - repeated with cy = 1: addr 6, 7, 2.
4. Straight-line NOPs from address 30: addr 30, 31, 0, 1. JMP at 31 takes its target from word 0.
5. Reset pulse of 3 ns while in OPER: addr = 0 and controls = 0 immediately (async, no clock edge). The next fetch is at 0.
6. FD_CALL_EN defined: CALL at 2 (target 0x0A), RET at 10 -> addr 2, 3, 10, 4. Without the macro, 0xC0 behaves as NOP -> addr 2, 3.
